// File: rtl/reaction_pkg.sv
// Shared types and default sizing for the reaction-time measurement block.
package reaction_pkg;

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned MAX_MS = 9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == ARMED) || (s == TIMING);
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Game-side handshake bundle for reaction_timer: trial control in, result and flags out.
interface reaction_timer_if
  import reaction_pkg::*;
#(
  parameter int unsigned CNT_W = reaction_pkg::CNT_W
);

  logic             tick_ms;
  logic             arm;
  logic             lights_out;
  logic             key;
  logic [CNT_W-1:0] rt_ms;
  logic             rt_valid;
  logic             false_start;
  logic             overrun;
  logic             busy;

  modport master (
    output tick_ms, arm, lights_out, key,
    input  rt_ms, rt_valid, false_start, overrun, busy
  );

  modport slave (
    input  tick_ms, arm, lights_out, key,
    output rt_ms, rt_valid, false_start, overrun, busy
  );

endinterface

// File: rtl/reaction_timer_key_sync_edge.sv
// Player key synchroniser and rising-edge detector; press is a registered one-clk pulse.
// Define REACTION_DEBOUNCE_EN to require the key stable across two tick_ms pulses.
module key_sync_edge
  import reaction_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic key,
  output logic press
);

  logic [1:0] sync_q;
  logic       press_q, press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key};
      press_q <= press_d;
    end
  end

`ifdef REACTION_DEBOUNCE_EN
  // Count consecutive ticks with the synchronised key high; any low sample restarts it.
  logic [1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    if (!sync_q[1]) begin
      db_cnt_d = 2'd0;
    end else if (tick_ms && (db_cnt_q != 2'd2)) begin
      db_cnt_d = db_cnt_q + 2'd1;
    end
    press_d = (db_cnt_d == 2'd2) && (db_cnt_q != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= 2'd0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  logic sync3_q;
  logic tick_unused;

  assign tick_unused = tick_ms;

  always_comb begin
    press_d = sync_q[1] & ~sync3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync3_q <= 1'b0;
    end else begin
      sync3_q <= sync_q[1];
    end
  end
`endif

  assign press = press_q;

endmodule

// File: rtl/reaction_timer.sv
// Counts milliseconds from lights_out to the player's key press and latches the result.
// Optional key debounce in the sub-module is enabled by defining REACTION_DEBOUNCE_EN.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int unsigned CNT_W  = reaction_pkg::CNT_W,
  parameter int unsigned MAX_MS = reaction_pkg::MAX_MS
)(
  input  logic             clk,
  input  logic             rst,
  reaction_timer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MAX_M1_V = CNT_W'(MAX_MS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rt_ms_q, rt_ms_d;
  logic             rt_valid_q, rt_valid_d;
  logic             false_start_q, false_start_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             press;

  key_sync_edge u_key (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (bus.tick_ms),
    .key     (bus.key),
    .press   (press)
  );

  // Trial sequencing; arm overrides every other event in every state.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rt_ms_d       = rt_ms_q;
    rt_valid_d    = 1'b0;
    false_start_d = false_start_q;
    overrun_d     = overrun_q;

    if (bus.arm) begin
      state_d       = ARMED;
      count_d       = '0;
      false_start_d = 1'b0;
      overrun_d     = 1'b0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (bus.lights_out && press) begin
            state_d    = DONE;
            count_d    = '0;
            rt_ms_d    = '0;
            rt_valid_d = 1'b1;
          end else if (bus.lights_out) begin
            state_d = TIMING;
            count_d = '0;
          end else if (press) begin
            state_d       = DONE;
            false_start_d = 1'b1;
          end
        end
        TIMING: begin
          if (press) begin
            // A press on the tick that would reach the limit is still a genuine result.
            state_d    = DONE;
            rt_ms_d    = (bus.tick_ms && (count_q == MAX_M1_V)) ? MAX_V : count_q;
            rt_valid_d = 1'b1;
          end else if (bus.tick_ms) begin
            if (count_q >= MAX_M1_V) begin
              state_d   = DONE;
              count_d   = MAX_V;
              rt_ms_d   = MAX_V;
              overrun_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rt_ms_q       <= '0;
      rt_valid_q    <= 1'b0;
      false_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rt_ms_q       <= rt_ms_d;
      rt_valid_q    <= rt_valid_d;
      false_start_q <= false_start_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rt_ms       = rt_ms_q;
  assign bus.rt_valid    = rt_valid_q;
  assign bus.false_start = false_start_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer (default build, raw synchronised key edge).
module tb_reaction_timer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   vcnt;
  int   v0;

  reaction_timer_if #(.CNT_W(14)) bus ();

  reaction_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rt_valid === 1'b1) vcnt = vcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
  endtask

  task automatic pulse_lights();
    bus.lights_out = 1'b1; step(); bus.lights_out = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.tick_ms = 1'b1; step(); bus.tick_ms = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tick_ms = 1'b0; bus.arm = 1'b0; bus.lights_out = 1'b0; bus.key = 1'b0;
    step(); step();
    checks++;
    if (bus.rt_ms !== 14'd0 || bus.rt_valid !== 1'b0 || bus.false_start !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rt_ms=%0d valid=%b fs=%b ov=%b busy=%b, required all 0",
               bus.rt_ms, bus.rt_valid, bus.false_start, bus.overrun, bus.busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    pulse_arm();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL basic_busy_armed: busy=%b required 1", bus.busy);
    end
    pulse_lights();
    tick_n(250);
    v0 = vcnt;
    bus.key = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd250 || bus.false_start !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: valid=%b rt_ms=%0d fs=%b ov=%b busy=%b, required 1/250/0/0/0",
               bus.rt_valid, bus.rt_ms, bus.false_start, bus.overrun, bus.busy);
    end
    repeat (4) step();
    checks++;
    if (vcnt - v0 !== 1 || bus.rt_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_single_pulse: pulses=%0d valid=%b, required 1/0", vcnt - v0, bus.rt_valid);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_false_start();
    v0 = vcnt;
    pulse_arm();
    repeat (10) step();
    bus.key = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.false_start !== 1'b1 || bus.rt_ms !== 14'd250 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL false_start: fs=%b rt_ms=%0d busy=%b, required 1/250/0",
               bus.false_start, bus.rt_ms, bus.busy);
    end
    bus.key = 1'b0;
    repeat (3) step();
    checks++;
    if (vcnt !== v0) begin
      failures++; $display("FAIL false_start_no_valid: pulses=%0d required 0", vcnt - v0);
    end
  endtask

  task automatic test_overrun();
    v0 = vcnt;
    pulse_arm();
    checks++;
    if (bus.false_start !== 1'b0) begin
      failures++; $display("FAIL arm_clears_fs: fs=%b required 0", bus.false_start);
    end
    pulse_lights();
    tick_n(9998);
    checks++;
    if (bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pre: ov=%b busy=%b, required 0/1", bus.overrun, bus.busy);
    end
    tick_n(1);
    checks++;
    if (bus.overrun !== 1'b1 || bus.rt_ms !== 14'd9999 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_hit: ov=%b rt_ms=%0d busy=%b, required 1/9999/0",
               bus.overrun, bus.rt_ms, bus.busy);
    end
    tick_n(5);
    checks++;
    if (bus.overrun !== 1'b1 || bus.rt_ms !== 14'd9999 || vcnt !== v0) begin
      failures++;
      $display("FAIL overrun_hold: ov=%b rt_ms=%0d pulses=%0d, required 1/9999/0",
               bus.overrun, bus.rt_ms, vcnt - v0);
    end
  endtask

  task automatic test_press_at_max();
    pulse_arm();
    checks++;
    if (bus.overrun !== 1'b0) begin
      failures++; $display("FAIL arm_clears_ov: ov=%b required 0", bus.overrun);
    end
    pulse_lights();
    tick_n(9998);
    bus.key = 1'b1;
    repeat (3) step();
    bus.tick_ms = 1'b1; step(); bus.tick_ms = 1'b0;
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd9999 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL press_at_max: valid=%b rt_ms=%0d ov=%b, required 1/9999/0",
               bus.rt_valid, bus.rt_ms, bus.overrun);
    end
  endtask

  task automatic test_key_held();
    // key remains high from the previous trial
    repeat (4) step();
    v0 = vcnt;
    pulse_arm();
    pulse_lights();
    tick_n(7);
    checks++;
    if (bus.busy !== 1'b1 || bus.false_start !== 1'b0 || vcnt !== v0) begin
      failures++;
      $display("FAIL key_held_ignored: busy=%b fs=%b pulses=%0d, required 1/0/0",
               bus.busy, bus.false_start, vcnt - v0);
    end
    bus.key = 1'b0;
    repeat (4) step();
    bus.key = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd7) begin
      failures++;
      $display("FAIL key_held_next_edge: valid=%b rt_ms=%0d, required 1/7", bus.rt_valid, bus.rt_ms);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_rearm_mid_timing();
    pulse_arm();
    pulse_lights();
    tick_n(40);
    pulse_arm();
    checks++;
    if (bus.busy !== 1'b1 || bus.false_start !== 1'b0 || bus.overrun !== 1'b0 || bus.rt_ms !== 14'd7) begin
      failures++;
      $display("FAIL rearm_state: busy=%b fs=%b ov=%b rt_ms=%0d, required 1/0/0/7",
               bus.busy, bus.false_start, bus.overrun, bus.rt_ms);
    end
    tick_n(3);
    pulse_lights();
    tick_n(5);
    bus.key = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd5) begin
      failures++;
      $display("FAIL rearm_result: valid=%b rt_ms=%0d, required 1/5", bus.rt_valid, bus.rt_ms);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_press_with_tick();
    pulse_arm();
    pulse_lights();
    tick_n(17);
    bus.key = 1'b1;
    repeat (3) step();
    bus.tick_ms = 1'b1; step(); bus.tick_ms = 1'b0;
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd17) begin
      failures++;
      $display("FAIL press_with_tick: valid=%b rt_ms=%0d, required 1/17", bus.rt_valid, bus.rt_ms);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_lights_with_press();
    pulse_arm();
    bus.key = 1'b1;
    repeat (3) step();
    pulse_lights();
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd0 || bus.false_start !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL lights_with_press: valid=%b rt_ms=%0d fs=%b busy=%b, required 1/0/0/0",
               bus.rt_valid, bus.rt_ms, bus.false_start, bus.busy);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_trial();
    pulse_arm();
    pulse_lights();
    tick_n(12);
    bus.key = 1'b1;
    repeat (4) step();
    bus.key = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.rt_ms !== 14'd12) begin
      failures++; $display("FAIL pre_reset_result: rt_ms=%0d required 12", bus.rt_ms);
    end
    pulse_arm();
    pulse_lights();
    tick_n(4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.rt_ms !== 14'd0 || bus.rt_valid !== 1'b0 || bus.false_start !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rt_ms=%0d valid=%b fs=%b ov=%b busy=%b, required all 0",
               bus.rt_ms, bus.rt_valid, bus.false_start, bus.overrun, bus.busy);
    end
    step();
    rst = 1'b0;
    step();
    pulse_arm();
    pulse_lights();
    tick_n(2);
    bus.key = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.rt_valid !== 1'b1 || bus.rt_ms !== 14'd2) begin
      failures++;
      $display("FAIL post_reset_trial: valid=%b rt_ms=%0d, required 1/2", bus.rt_valid, bus.rt_ms);
    end
    bus.key = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vcnt     = 0;
    test_reset();
    test_basic();
    test_false_start();
    test_overrun();
    test_press_at_max();
    test_key_held();
    test_rearm_mid_timing();
    test_press_with_tick();
    test_lights_with_press();
    test_reset_mid_trial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
